// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: opcode field, default HALT opcode, FSM states.
package if_prefetch_queue_pkg;

  localparam int unsigned OPC_W = 6;
  localparam logic [OPC_W-1:0] DEFAULT_HALT_OP = 6'b111011;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// DEPTH-entry registered FIFO of {instr, pc1} words with flush; head is the entry at rd_ptr.
module if_prefetch_queue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: PC generation, epoch-tagged imem requests, prefetch FIFO to decode, HALT stop.
// Optional perf counters (perf_fetched / perf_flushed) are enabled with `define IF_PERF_CNT_EN.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [OPC_W-1:0]  HALT_OP  = DEFAULT_HALT_OP
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_valid,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc1,
  output logic              halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic              inflight_q, inflight_d, tag_q, tag_d, epoch_q, epoch_d;
  if_state_e         state_q, state_d;

  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head, wdata;
  logic [OCC_W-1:0]  occ;
  logic              issue, push, pop, is_halt;

  // Issue/response/FSM next-state; redirect overrides everything else.
  always_comb begin
    occ     = OCC_W'(count) + OCC_W'(inflight_q);
    issue   = !reset && (state_q == ST_FETCH) && !redirect && (occ < OCC_W'(DEPTH));
    push    = imem_valid && inflight_q && (tag_q == epoch_q) && !redirect;
    pop     = (count != '0) && !id_stall && !redirect;
    is_halt = (imem_data[DATA_W-1 -: OPC_W] == HALT_OP);
    wdata   = {imem_data, addr_q + ADDR_W'(1)};

    pc_d       = pc_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    epoch_d    = epoch_q;
    state_d    = state_q;
    inflight_d = issue;
    if (issue) begin
      pc_d   = pc_q + ADDR_W'(1);
      addr_d = pc_q;
      tag_d  = epoch_q;
    end
    if (push && is_halt) state_d = ST_HALTED;
    if (redirect) begin
      pc_d    = redirect_target;
      epoch_d = ~epoch_q;
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      epoch_q    <= 1'b0;
      state_q    <= ST_FETCH;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      epoch_q    <= epoch_d;
      state_q    <= state_d;
    end
  end

  if_prefetch_queue_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign id_valid  = (count != '0);
  assign id_instr  = head[ENT_W-1 -: DATA_W];
  assign id_pc1    = head[ADDR_W-1:0];
  assign halted    = (state_q == ST_HALTED);

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d;
  logic [32:0] fetched_sum, flushed_sum;

  // Saturating counters; a redirect discards the queued words plus any response arriving with it.
  always_comb begin
    fetched_sum = {1'b0, fetched_q} + 33'(push);
    flushed_sum = {1'b0, flushed_q} + 33'(count) + 33'(imem_valid && inflight_q);
    fetched_d   = fetched_sum[32] ? '1 : fetched_sum[31:0];
    flushed_d   = flushed_q;
    if (redirect) flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed table, hand sequences, randomized run against a queue model.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] HALT_WORD = 32'hEC000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        imem_valid = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc1;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  if_prefetch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .imem_valid      (imem_valid),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc1          (id_pc1),
    .halted          (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_flushed    (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc1;
  } entry_t;

  typedef struct {
    bit          stall;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc1;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  entry_t      m_q[$];
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_addr;
  bit          m_halt;
  longint      m_fetched, m_flushed;
  logic [31:0] halt_addr = 32'h7FFF_FFFF;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == halt_addr) ? HALT_WORD : a + 32'd100;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc      = 32'h0;
    m_infl    = 1'b0;
    m_halt    = 1'b0;
    m_fetched = 0;
    m_flushed = 0;
  endtask

  function automatic bit exp_req_f();
    return !m_halt && !redirect && ((m_q.size() + int'(m_infl)) < DEPTH);
  endfunction

  task automatic check_model();
    bit rq;
    rq = exp_req_f();
    chk("imem_req", 64'(imem_req), 64'(rq));
    if (rq) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("id_valid", 64'(id_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("id_instr", 64'(id_instr), 64'(m_q[0].instr));
      chk("id_pc1", 64'(id_pc1), 64'(m_q[0].pc1));
    end
    chk("halted", 64'(halted), 64'(m_halt));
  endtask

  task automatic model_step();
    entry_t e;
    bit rq, push_ok, pop_ok;
    rq      = exp_req_f();
    push_ok = imem_valid && m_infl && !redirect;
    pop_ok  = (m_q.size() > 0) && !id_stall && !redirect;
    if (redirect) begin
      m_flushed += m_q.size() + ((imem_valid && m_infl) ? 1 : 0);
      m_q.delete();
      m_pc   = redirect_target;
      m_halt = 1'b0;
      m_infl = 1'b0;
    end else begin
      if (pop_ok) void'(m_q.pop_front());
      if (push_ok) begin
        e.instr = imem_data;
        e.pc1   = m_infl_addr + 32'd1;
        m_q.push_back(e);
        m_fetched++;
        if (imem_data[31:26] == 6'b111011) m_halt = 1'b1;
      end
      if (rq) begin
        m_infl      = 1'b1;
        m_infl_addr = m_pc;
        m_pc        = m_pc + 32'd1;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  // Entered and left at a negedge; inputs set by the caller just before.
  task automatic tick(input bit chk_model);
    logic        req_s;
    logic [31:0] addr_s;
    #1;
    if (chk_model) check_model();
    model_step();
    req_s  = imem_req;
    addr_s = imem_addr;
    @(posedge clk);
    #1;
    imem_valid = req_s;
    imem_data  = req_s ? mem_f(addr_s) : 32'h0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, 64'(imem_req), 64'(0));
    chk({tag, "_id_valid"}, 64'(id_valid), 64'(0));
    chk({tag, "_id_instr"}, 64'(id_instr), 64'(0));
    chk({tag, "_id_pc1"}, 64'(id_pc1), 64'(0));
    chk({tag, "_halted"}, 64'(halted), 64'(0));
  endtask

  vec_t tab[13];

  initial begin
    int k;
    logic [31:0] flushed_before;
    flushed_before = '0;

    tab[0]  = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0,   32'd0};
    tab[1]  = '{1'b0, 1'b1, 32'd1, 1'b0, 32'd0,   32'd0};
    tab[2]  = '{1'b0, 1'b1, 32'd2, 1'b1, 32'd100, 32'd1};
    tab[3]  = '{1'b0, 1'b1, 32'd3, 1'b1, 32'd101, 32'd2};
    tab[4]  = '{1'b1, 1'b1, 32'd4, 1'b1, 32'd102, 32'd3};
    tab[5]  = '{1'b1, 1'b1, 32'd5, 1'b1, 32'd102, 32'd3};
    tab[6]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd102, 32'd3};
    tab[7]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd102, 32'd3};
    tab[8]  = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd102, 32'd3};
    tab[9]  = '{1'b0, 1'b1, 32'd6, 1'b1, 32'd103, 32'd4};
    tab[10] = '{1'b0, 1'b1, 32'd7, 1'b1, 32'd104, 32'd5};
    tab[11] = '{1'b0, 1'b1, 32'd8, 1'b1, 32'd105, 32'd6};
    tab[12] = '{1'b0, 1'b1, 32'd9, 1'b1, 32'd106, 32'd7};

    // Power-on reset
    model_reset();
    @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Streaming, then stall fill and drain
    for (int i = 0; i < 13; i++) begin
      id_stall = tab[i].stall;
      #1;
      chk($sformatf("tab%0d_req", i), 64'(imem_req), 64'(tab[i].exp_req));
      if (tab[i].exp_req) chk($sformatf("tab%0d_addr", i), 64'(imem_addr), 64'(tab[i].exp_addr));
      chk($sformatf("tab%0d_valid", i), 64'(id_valid), 64'(tab[i].exp_valid));
      if (tab[i].exp_valid) begin
        chk($sformatf("tab%0d_instr", i), 64'(id_instr), 64'(tab[i].exp_instr));
        chk($sformatf("tab%0d_pc1", i), 64'(id_pc1), 64'(tab[i].exp_pc1));
      end
      tick(1'b0);
    end

    // Redirect with 3 queued and 1 in flight
    id_stall = 1'b1;
    k = 0;
    while (!(m_q.size() == 3 && m_infl) && k < 20) begin tick(1'b1); k++; end
    if (k == 20) bound_expired("wait_q3");
`ifdef IF_PERF_CNT_EN
    flushed_before = perf_flushed;
`endif
    id_stall = 1'b0;
    redirect = 1'b1;
    redirect_target = 32'h40;
    tick(1'b1);
    redirect = 1'b0;
    #1;
    chk("rd_valid_after", 64'(id_valid), 64'(0));
    chk("rd_req_after", 64'(imem_req), 64'(1));
    chk("rd_addr_after", 64'(imem_addr), 64'(32'h40));
`ifdef IF_PERF_CNT_EN
    chk("rd_perf_flushed", 64'(perf_flushed - flushed_before), 64'(4));
`endif
    tick(1'b1);
    tick(1'b1);
    chk("rd_first_instr", 64'(id_instr), 64'(32'h40 + 32'd100));
    chk("rd_first_pc1", 64'(id_pc1), 64'(32'h41));
    chk("rd_first_valid", 64'(id_valid), 64'(1));

    // HALT word at address 5
    halt_addr = 32'd5;
    redirect = 1'b1;
    redirect_target = 32'd2;
    tick(1'b1);
    redirect = 1'b0;
    k = 0;
    while (!(m_halt && m_q.size() == 0 && !m_infl) && k < 30) begin
      if (m_q.size() > 0 && m_q[0].instr == HALT_WORD)
        chk("halt_word_delivered", 64'(id_instr), 64'(HALT_WORD));
      tick(1'b1);
      k++;
    end
    if (k == 30) bound_expired("wait_halt");
    #1;
    chk("halt_flag", 64'(halted), 64'(1));
    chk("halt_no_req", 64'(imem_req), 64'(0));
    tick(1'b1);
    redirect = 1'b1;
    redirect_target = 32'h10;
    tick(1'b1);
    redirect = 1'b0;
    #1;
    chk("unhalt_flag", 64'(halted), 64'(0));
    chk("unhalt_req", 64'(imem_req), 64'(1));
    chk("unhalt_addr", 64'(imem_addr), 64'(32'h10));

    // Redirect and stall together with a full FIFO
    id_stall = 1'b1;
    k = 0;
    while (m_q.size() != DEPTH && k < 20) begin tick(1'b1); k++; end
    if (k == 20) bound_expired("wait_full");
    redirect = 1'b1;
    redirect_target = 32'h80;
    tick(1'b1);
    redirect = 1'b0;
    #1;
    chk("full_rd_valid", 64'(id_valid), 64'(0));
    chk("full_rd_addr", 64'(imem_addr), 64'(32'h80));
    tick(1'b1);
    #1;
    chk("full_rd_valid2", 64'(id_valid), 64'(0));
    tick(1'b1);
    #1;
    chk("full_rd_valid3", 64'(id_valid), 64'(1));
    chk("full_rd_instr", 64'(id_instr), 64'(32'h80 + 32'd100));
    chk("full_rd_pc1", 64'(id_pc1), 64'(32'h81));
    id_stall = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      id_stall = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 15) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 40));
      tick(1'b1);
    end
    redirect = 1'b0;
    id_stall = 1'b0;
    tick(1'b1);
    redirect = 1'b1;
    redirect_target = 32'h200;
    tick(1'b1);
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    chk("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`endif

    // Reset mid-stream with a response arriving
    k = 0;
    while (!imem_valid && k < 10) begin tick(1'b1); k++; end
    if (k == 10) bound_expired("wait_imem_valid");
    reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    @(posedge clk);
    #1;
    imem_valid = 1'b1;
    imem_data  = 32'h1234_5678;
    @(negedge clk);
    chk("mid_no_enqueue", 64'(id_valid), 64'(0));
    reset = 1'b0;
    model_reset();
    halt_addr = 32'h7FFF_FFFF;
    for (int i = 0; i < 8; i++) tick(1'b1);
    chk("restart_instr", 64'(id_instr), 64'(m_q.size() > 0 ? m_q[0].instr : 32'hDEAD));
`ifdef IF_PERF_CNT_EN
    chk("restart_perf_fetched", 64'(perf_fetched), 64'(m_fetched));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
